// File: rtl/neosd_cmd_arb_if.sv
// Bundle of the requester, engine and response handshakes around neosd_cmd_arb.
// Requester fields are indexed by requester id (0: CPU/register path, 1: boot/DMA loader).
interface neosd_cmd_arb_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][5:0]  req_idx;
  logic [1:0][31:0] req_arg;
  logic [1:0][6:0]  req_crc;
  logic [1:0][1:0]  req_rmode;

  logic             eng_commit;
  logic [5:0]       eng_idx;
  logic [31:0]      eng_arg;
  logic [6:0]       eng_crc;
  logic [1:0]       eng_rmode;
  logic             eng_abort;
  logic             eng_done;
  logic [31:0]      eng_resp0;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_timeout;
  logic [31:0]      rsp_data;

  modport master (
    output req_valid, req_idx, req_arg, req_crc, req_rmode,
    input  req_ready,
    input  eng_commit, eng_idx, eng_arg, eng_crc, eng_rmode, eng_abort,
    output eng_done, eng_resp0,
    input  rsp_valid, rsp_id, rsp_timeout, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_idx, req_arg, req_crc, req_rmode,
    output req_ready,
    output eng_commit, eng_idx, eng_arg, eng_crc, eng_rmode, eng_abort,
    input  eng_done, eng_resp0,
    output rsp_valid, rsp_id, rsp_timeout, rsp_data,
    input  rsp_ready
  );
endinterface

// File: rtl/neosd_cmd_arb.sv
// Round-robin two-requester command arbiter/sequencer for the NEOSD command engine.
// Optional: define NEOSD_CMD_ARB_RETRY_EN to reissue a command once after its first timeout.
module neosd_cmd_arb #(
  parameter int TIMEOUT_TICKS = 1024,
  parameter int GAP_TICKS     = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sd_clk_tick_i,
  neosd_cmd_arb_if.slave bus
);
`ifdef NEOSD_CMD_ARB_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif
  localparam int TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_TICKS - 1);
  localparam bit GapNone = (GAP_TICKS == 0);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          rr_q, retry_q, regap_q;
  logic          grant, gnt, done_hit, to_hit, first_to, abort;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    gcnt_d   = gcnt_q;
    grant    = 1'b0;
    gnt      = 1'b0;
    done_hit = 1'b0;
    to_hit   = 1'b0;
    first_to = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: if (|bus.req_valid) begin
        grant   = 1'b1;
        gnt     = (&bus.req_valid) ? rr_q : bus.req_valid[1];
        state_d = ISSUE;
      end
      ISSUE: if (sd_clk_tick_i) begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        // done has priority over a timeout landing on the same tick
        if (bus.eng_done) begin
          done_hit = 1'b1;
          state_d  = RESP;
        end else if (sd_clk_tick_i) begin
          if (tcnt_q == TLAST) begin
            abort = 1'b1;
            if (RetryEn && !retry_q) begin
              first_to = 1'b1;
              gcnt_d   = '0;
              state_d  = GAP;
            end else begin
              to_hit  = 1'b1;
              state_d = RESP;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      RESP: if (bus.rsp_ready) begin
        state_d = GAP;
        gcnt_d  = '0;
      end
      GAP: begin
        if (GapNone) begin
          state_d = regap_q ? ISSUE : IDLE;
        end else if (sd_clk_tick_i) begin
          if (gcnt_q == GLAST) state_d = regap_q ? ISSUE : IDLE;
          else                 gcnt_d  = gcnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      tcnt_q          <= '0;
      gcnt_q          <= '0;
      rr_q            <= 1'b0;
      retry_q         <= 1'b0;
      regap_q         <= 1'b0;
      bus.eng_idx     <= '0;
      bus.eng_arg     <= '0;
      bus.eng_crc     <= '0;
      bus.eng_rmode   <= '0;
      bus.rsp_id      <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.rsp_data    <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      if (grant) begin
        bus.eng_idx   <= bus.req_idx[gnt];
        bus.eng_arg   <= bus.req_arg[gnt];
        bus.eng_crc   <= bus.req_crc[gnt];
        bus.eng_rmode <= bus.req_rmode[gnt];
        bus.rsp_id    <= gnt;
        rr_q          <= ~gnt;
        retry_q       <= 1'b0;
      end
      if (done_hit) begin
        bus.rsp_timeout <= 1'b0;
        bus.rsp_data    <= (bus.eng_rmode == 2'd0) ? 32'd0 : bus.eng_resp0;
      end
      if (to_hit) begin
        bus.rsp_timeout <= 1'b1;
        bus.rsp_data    <= '0;
      end
      if (first_to) begin
        retry_q <= 1'b1;
        regap_q <= 1'b1;
      end
      if (state_q == GAP && state_d != GAP) regap_q <= 1'b0;
    end
  end

  // ready is combinational so the winner sees acceptance in its valid cycle
  assign bus.req_ready  = (grant && !rst_i) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.eng_commit = (state_q == ISSUE);
  assign bus.eng_abort  = abort;
  assign bus.rsp_valid  = (state_q == RESP);
endmodule

// File: tb/tb_neosd_cmd_arb.sv
// Directed bench for neosd_cmd_arb: grant order, commit/timeout/abort timing, gap and reset.
module tb_neosd_cmd_arb;
  localparam int TO  = 16;
  localparam int GAP = 8;
`ifdef NEOSD_CMD_ARB_RETRY_EN
  localparam int NTRY = 2;
`else
  localparam int NTRY = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n_abort = 0;
  int   n_commit = 0;
  logic commit_d = 1'b0;

  neosd_cmd_arb_if bus();

  neosd_cmd_arb #(.TIMEOUT_TICKS(TO), .GAP_TICKS(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .sd_clk_tick_i(tick), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.eng_abort) n_abort = n_abort + 1;
    if (bus.eng_commit && !commit_d) n_commit = n_commit + 1;
    commit_d = bus.eng_commit;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk); #2;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk); #2;
    tick = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clk1(); clk1();
    rst = 1'b0;
    #1;
  endtask

  // from ISSUE: end commit, return done, accept response, run out the gap
  task automatic finish_cmd(input string tag, input logic id, input logic [31:0] resp,
                            input logic [31:0] exp_data);
    do_tick();
    bus.eng_done = 1'b1; bus.eng_resp0 = resp;
    clk1();
    bus.eng_done = 1'b0;
    #1;
    chk({tag, "_valid"}, bus.rsp_valid, 1);
    chk({tag, "_id"}, bus.rsp_id, id);
    chk({tag, "_data"}, bus.rsp_data, exp_data);
    bus.rsp_ready = 1'b1;
    clk1();
    bus.rsp_ready = 1'b0;
    repeat (GAP) do_tick();
    #1;
  endtask

  initial begin : main
    int k, first_abort, na0, nc0, bad;
    logic [31:0] hold_data;
    bus.req_valid = '0; bus.req_idx = '0; bus.req_arg = '0; bus.req_crc = '0; bus.req_rmode = '0;
    bus.eng_done = 1'b0; bus.eng_resp0 = '0; bus.rsp_ready = 1'b0;

    // reset state, requesters already valid
    bus.req_valid = 2'b11;
    clk1(); #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_commit", bus.eng_commit, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_abort", bus.eng_abort, 0);
    bus.req_valid = 2'b00;
    reset_dut();

    // single command from req0
    bus.req_idx[0] = 6'd8; bus.req_arg[0] = 32'h1AA; bus.req_crc[0] = 7'h43; bus.req_rmode[0] = 2'd1;
    bus.req_valid = 2'b01;
    #1;
    chk("t1_ready", bus.req_ready, 2'b01);
    clk1();
    bus.req_valid = 2'b00;
    #1;
    chk("t1_commit", bus.eng_commit, 1);
    chk("t1_idx", bus.eng_idx, 8);
    chk("t1_arg", bus.eng_arg, 32'h1AA);
    chk("t1_crc", bus.eng_crc, 7'h43);
    clk1(); #1;
    chk("t1_commit_hold", bus.eng_commit, 1);
    do_tick(); #1;
    chk("t1_commit_end", bus.eng_commit, 0);
    repeat (9) do_tick();
    bus.eng_done = 1'b1; bus.eng_resp0 = 32'h1AA;
    clk1();
    bus.eng_done = 1'b0;
    #1;
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_id", bus.rsp_id, 0);
    chk("t1_rsp_to", bus.rsp_timeout, 0);
    chk("t1_rsp_data", bus.rsp_data, 32'h1AA);
    bus.rsp_ready = 1'b1;
    clk1();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b10;
    #1;
    chk("t1_gap_valid", bus.rsp_valid, 0);
    chk("t1_gap_ready0", bus.req_ready, 0);
    repeat (GAP - 1) do_tick();
    #1;
    chk("t1_gap_ready7", bus.req_ready, 0);
    do_tick(); #1;
    chk("t1_gap_done", bus.req_ready, 2'b10);
    bus.req_valid = 2'b00;
    reset_dut();

    // round-robin with both requesters held valid
    bus.req_idx[0] = 6'd17; bus.req_arg[0] = 32'hA0; bus.req_rmode[0] = 2'd1;
    bus.req_idx[1] = 6'd18; bus.req_arg[1] = 32'hB1; bus.req_rmode[1] = 2'd2;
    bus.req_valid = 2'b11;
    #1;
    chk("rr1_ready", bus.req_ready, 2'b01);
    clk1(); #1;
    chk("rr1_idx", bus.eng_idx, 17);
    finish_cmd("rr1", 1'b0, 32'h11, 32'h11);
    chk("rr2_ready", bus.req_ready, 2'b10);
    clk1(); #1;
    chk("rr2_idx", bus.eng_idx, 18);
    chk("rr2_rmode", bus.eng_rmode, 2);
    bus.req_rmode[0] = 2'd0;
    finish_cmd("rr2", 1'b1, 32'h22, 32'h22);
    chk("rr3_ready", bus.req_ready, 2'b01);
    clk1();
    finish_cmd("rr3", 1'b0, 32'h33, 32'h0);
    bus.req_valid = 2'b00;
    reset_dut();

    // timeout: engine never answers
    bus.req_rmode[0] = 2'd1;
    bus.req_valid = 2'b01;
    na0 = n_abort; nc0 = n_commit;
    clk1();
    bus.req_valid = 2'b00;
    do_tick();
    k = 0; first_abort = 0;
    while (!bus.rsp_valid && k < 200) begin
      tick = 1'b1; #1;
      if (bus.eng_abort && first_abort == 0) first_abort = k + 1;
      @(posedge clk); #2;
      tick = 1'b0;
      k++;
    end
    #1;
    chk("to_first_abort_tick", first_abort, TO);
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_abort_cycles", n_abort - na0, NTRY);
    chk("to_commits", n_commit - nc0, NTRY);
    chk("to_flag", bus.rsp_timeout, 1);
    chk("to_data", bus.rsp_data, 0);
    chk("to_abort_low", bus.eng_abort, 0);
    bus.rsp_ready = 1'b1;
    clk1();
    bus.rsp_ready = 1'b0;
    repeat (GAP) do_tick();

    // done on the final tick wins over the timeout
    bus.req_valid = 2'b01;
    na0 = n_abort;
    clk1();
    bus.req_valid = 2'b00;
    do_tick();
    repeat (TO - 1) do_tick();
    tick = 1'b1; bus.eng_done = 1'b1; bus.eng_resp0 = 32'hCAFE0001;
    #1;
    chk("race_abort", bus.eng_abort, 0);
    @(posedge clk); #2;
    tick = 1'b0; bus.eng_done = 1'b0;
    #1;
    chk("race_valid", bus.rsp_valid, 1);
    chk("race_to", bus.rsp_timeout, 0);
    chk("race_data", bus.rsp_data, 32'hCAFE0001);
    chk("race_no_abort", n_abort - na0, 0);

    // consumer stalls 50 cycles; stray done must not disturb the response
    bus.req_valid = 2'b10;
    hold_data = bus.rsp_data;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 10) begin bus.eng_done = 1'b1; bus.eng_resp0 = 32'h5555AAAA; end
      if (c == 11) bus.eng_done = 1'b0;
      tick = (c % 3 == 0);
      #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_timeout !== 1'b0 ||
          bus.rsp_data !== hold_data || bus.req_ready !== 2'b00) bad++;
      @(posedge clk); #2;
    end
    tick = 1'b0;
    chk("stall_stable_bad_cycles", bad, 0);
    bus.rsp_ready = 1'b1;
    clk1();
    bus.rsp_ready = 1'b0;
    repeat (GAP) do_tick();
    #1;
    chk("stall_then_req1", bus.req_ready, 2'b10);
    bus.req_valid = 2'b00;

    // reset in the middle of WAIT
    reset_dut();
    bus.req_idx[1] = 6'd55;
    bus.req_valid = 2'b10;
    clk1();
    do_tick();
    repeat (3) do_tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_commit", bus.eng_commit, 0);
    chk("mid_rst_abort", bus.eng_abort, 0);
    chk("mid_rst_ready", bus.req_ready, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_idx", bus.eng_idx, 0);
    clk1();
    rst = 1'b0;
    #1;
    chk("post_rst_req1_alone", bus.req_ready, 2'b10);
    bus.req_valid = 2'b11;
    #1;
    chk("post_rst_tie_req0", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    clk1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
